// File: rtl/dcache_responder_if.sv
// Bundles the CPU D-cache port and the physical-memory line port of dcache_responder.
// The cache takes the slave view; the surrounding datapath/arbiter takes the master view.
interface dcache_responder_if;
    logic         data_read;
    logic         data_write;
    logic [3:0]   data_mbe;
    logic [31:0]  data_addr;
    logic [31:0]  data_wdata;
    logic         data_resp;
    logic [31:0]  data_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    modport slave (
        input  data_read, data_write, data_mbe, data_addr, data_wdata,
        output data_resp, data_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output data_read, data_write, data_mbe, data_addr, data_wdata,
        input  data_resp, data_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate L1 data cache with 256-bit lines.
// One CPU request outstanding; misses write back a dirty victim, then fill and re-evaluate.
module dcache_responder #(
    parameter int unsigned S_INDEX = 3
) (
    input logic               clk,
    input logic               rst,
    dcache_responder_if.slave bus
);
    localparam int unsigned SETS  = 1 << S_INDEX;
    localparam int unsigned TAG_W = 27 - S_INDEX;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        WRITEBACK,
        ALLOCATE
    } state_e;

    state_e              state_q, state_d;
    logic [SETS-1:0]     valid_q, valid_d;
    logic [SETS-1:0]     dirty_q, dirty_d;
    logic [TAG_W-1:0]    tag_q  [SETS];
    logic [255:0]        line_q [SETS];

    logic                pmem_read_q,  pmem_read_d;
    logic                pmem_write_q, pmem_write_d;
    logic [31:0]         pmem_addr_q,  pmem_addr_d;
    logic [255:0]        pmem_wdata_q, pmem_wdata_d;
    logic [31:0]         rdata_q,      rdata_d;

    logic [S_INDEX-1:0]  idx;
    logic [TAG_W-1:0]    req_tag;
    logic [2:0]          wsel;
    logic [7:0]          wbit;
    logic                req;
    logic                hit;
    logic [255:0]        cur_line;
    logic [31:0]         cur_word;
    logic [31:0]         merged_word;

    logic                line_we;
    logic [255:0]        line_wdata;
    logic                tag_we;

    logic                unused_addr_bits;

    assign idx              = bus.data_addr[4+S_INDEX:5];
    assign req_tag          = bus.data_addr[31:5+S_INDEX];
    assign wsel             = bus.data_addr[4:2];
    assign wbit             = {wsel, 5'b0};
    assign unused_addr_bits = ^bus.data_addr[1:0];

    assign req      = bus.data_read | bus.data_write;
    assign cur_line = line_q[idx];
    assign cur_word = cur_line[wbit +: 32];
    assign hit      = valid_q[idx] && (tag_q[idx] == req_tag);

    always_comb begin
        merged_word = cur_word;
        for (int unsigned b = 0; b < 4; b++) begin
            if (bus.data_mbe[b]) begin
                merged_word[b*8 +: 8] = bus.data_wdata[b*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        pmem_read_d  = pmem_read_q;
        pmem_write_d = pmem_write_q;
        pmem_addr_d  = pmem_addr_q;
        pmem_wdata_d = pmem_wdata_q;
        rdata_d      = rdata_q;
        line_we      = 1'b0;
        line_wdata   = cur_line;
        tag_we       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        // store wins when both strobes are raised
                        if (bus.data_write) begin
                            line_we                  = 1'b1;
                            line_wdata[wbit +: 32]   = merged_word;
                            dirty_d[idx]             = dirty_q[idx] | (|bus.data_mbe);
                        end else begin
                            rdata_d = cur_word;
                        end
                        state_d = RESP;
                    end else if (valid_q[idx] && dirty_q[idx]) begin
                        pmem_write_d = 1'b1;
                        pmem_addr_d  = {tag_q[idx], idx, 5'b0};
                        pmem_wdata_d = cur_line;
                        state_d      = WRITEBACK;
                    end else begin
                        pmem_read_d  = 1'b1;
                        pmem_addr_d  = {req_tag, idx, 5'b0};
                        state_d      = ALLOCATE;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            WRITEBACK: begin
                if (bus.pmem_resp) begin
                    pmem_write_d = 1'b0;
                    pmem_read_d  = 1'b1;
                    pmem_addr_d  = {req_tag, idx, 5'b0};
                    state_d      = ALLOCATE;
                end
            end
            ALLOCATE: begin
                // fill then return to IDLE so the access re-resolves as a hit
                if (bus.pmem_resp) begin
                    pmem_read_d  = 1'b0;
                    line_we      = 1'b1;
                    line_wdata   = bus.pmem_rdata;
                    tag_we       = 1'b1;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            pmem_addr_q  <= '0;
            pmem_wdata_q <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
            pmem_addr_q  <= pmem_addr_d;
            pmem_wdata_q <= pmem_wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    // Line and tag storage carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (line_we) begin
            line_q[idx] <= line_wdata;
        end
        if (tag_we) begin
            tag_q[idx] <= req_tag;
        end
    end

    assign bus.data_resp    = (state_q == RESP);
    assign bus.data_rdata   = rdata_q;
    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.pmem_address = pmem_addr_q;
    assign bus.pmem_wdata   = pmem_wdata_q;
endmodule

// File: doc/dcache_responder.md
# dcache_responder

Direct-mapped, write-back, write-allocate L1 data cache serving the datapath's D-cache port (data_read/data_write/data_mbe/data_addr/data_wdata → data_resp/data_rdata). It is the responder end of that port: it resolves each CPU access against a local line array and, on a miss, initiates 256-bit line transfers on the physical-memory side toward the arbiter. It holds one outstanding CPU request at a time and completes it with a single-cycle data_resp pulse.

## Interface
- S_INDEX, 3, index bits; 2^S_INDEX sets of one 256-bit line each
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- data_read  input  1  CPU load request, held until data_resp
- data_write  input  1  CPU store request, held until data_resp
- data_mbe  input  4  byte enables for store; ignored for loads
- data_addr  input  32  byte address; bits [1:0] ignored
- data_wdata  input  32  store data, byte lanes per data_mbe
- data_resp  output  1  one-cycle completion pulse
- data_rdata  output  32  load word, valid while data_resp=1
- pmem_read  output  1  line fill request, held until pmem_resp
- pmem_write  output  1  line writeback request, held until pmem_resp
- pmem_address  output  32  line address, bits [4:0]=0
- pmem_wdata  output  256  victim line for writeback
- pmem_rdata  input  256  fill line, valid while pmem_resp=1
- pmem_resp  input  1  one-cycle completion of pmem transfer

## Operation
- Address split: offset [4:0], word select [4:2], index [4+S_INDEX:5], tag [31:5+S_INDEX].
- Per set: valid, dirty, tag, 256-bit data. Hit = valid && tag match.
- FSM states IDLE, RESP, WRITEBACK, ALLOCATE.
- IDLE, no request: stay. data_write has priority if both data_read and data_write are high.
- IDLE, hit: load captures selected word into data_rdata register; store merges data_wdata into selected word per data_mbe and sets dirty iff data_mbe≠0. → RESP.
- IDLE, miss, victim valid&&dirty: → WRITEBACK. Miss otherwise: → ALLOCATE.
- WRITEBACK: pmem_write=1, pmem_address={victim tag, index, 5'b0}, pmem_wdata=victim line; on pmem_resp → ALLOCATE.
- ALLOCATE: pmem_read=1, pmem_address={req tag, index, 5'b0}; on pmem_resp write pmem_rdata into line, valid=1, dirty=0, tag=req tag → IDLE (access then re-evaluates and hits).
- RESP: data_resp=1 for exactly one cycle, no array access, no new request accepted → IDLE.
- Never asserts pmem_read and pmem_write together.
- Line data, tags, and data_rdata register need no reset; valid and dirty bits do.

## Timing
- Reset (async, immediate): state=IDLE, all valid/dirty=0, data_resp=0, data_rdata=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
- Hit: request visible in IDLE at cycle 0 → data_resp high cycle 1 → IDLE cycle 2. CPU may present next request in cycle 2; throughput one access per 2 cycles.
- Clean miss, pmem latency L cycles (pmem_resp in L-th cycle of ALLOCATE): data_resp at cycle L+2.
- Dirty miss, writeback latency W, fill latency L: data_resp at cycle W+L+2.
- CPU inputs must be stable from request assertion through data_resp; changes before data_resp are undefined.
- pmem_read/pmem_write/pmem_address/pmem_wdata registered-stable through the whole WRITEBACK/ALLOCATE state; dropped in the cycle after pmem_resp.
- Reset during WRITEBACK/ALLOCATE aborts the transfer: pmem request drops immediately, no array update, no data_resp; the memory side must tolerate abandonment.
- pmem_resp outside WRITEBACK/ALLOCATE is ignored.

## Test plan
- Reset, then load 0x0000_0040 (clean miss), pmem returns line with word 0 = 0xDEAD_BEEF after 5 cycles → pmem_read cycles 1–5 at 0x0000_0040, data_resp cycle 7, data_rdata=0xDEAD_BEEF.
- Re-load 0x0000_0044 after fill → no pmem activity, data_resp cycle 1, data_rdata = word 1 of filled line.
- Store 0xAABB_CCDD mbe=4'b0101 to 0x0000_0040 then load same → data_rdata=0xDEBB_BEDD, set dirty.
- Load 0x0000_0140 (same index, new tag, S_INDEX=3) → pmem_write at 0x0000_0040 with modified line first, then pmem_read at 0x0000_0140, data_resp after W+L+2 cycles.
- Both data_read and data_write high to hit address → behaves as store, one data_resp pulse, dirty set.
- Assert rst mid-ALLOCATE → pmem_read drops same cycle, all outputs 0; subsequent load to same address misses again.
